// File: rtl/jtframe_db9_pkg.sv
// -----------------------------------------------------------------------------
// jtframe_db9_pkg
// Shared constants for the Neptuno/MC2 DB9 front end: joystick word bit
// positions, raw pad-line positions inside one port's slice of the serial
// chain, Megadrive SELECT phase numbers and the scan FSM state encoding.
//
// Build option: JTFRAME_DB9_6BTN_EN
//   defined   - full 8-phase Megadrive sequence, X/Y/Z/Mode and six-button
//               detection active.
//   undefined - only phases 0 and 1 are scanned; X/Y/Z/Mode and the
//               six-button flags are forced to 0.
// -----------------------------------------------------------------------------
package jtframe_db9_pkg;

    // Active-high joystick word layout
    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_A     = 4;
    localparam int JOY_X     = 5;
    localparam int JOY_C     = 6;
    localparam int JOY_B     = 7;
    localparam int JOY_Y     = 8;
    localparam int JOY_Z     = 9;
    localparam int JOY_START = 10;
    localparam int JOY_MODE  = 11;

    // Order in which a port's lines come out of the shift register
    localparam int RAW_U  = 0;
    localparam int RAW_D  = 1;
    localparam int RAW_L  = 2;
    localparam int RAW_R  = 3;
    localparam int RAW_P6 = 4;
    localparam int RAW_P9 = 5;

    // SELECT phases (even phases drive SELECT high)
    localparam logic [2:0] PH_DIR0 = 3'd0;
    localparam logic [2:0] PH_ABS  = 3'd1;
    localparam logic [2:0] PH_DIR2 = 3'd2;
    localparam logic [2:0] PH_DIR4 = 3'd4;
    localparam logic [2:0] PH_ID   = 3'd5;
    localparam logic [2:0] PH_EXT  = 3'd6;

`ifdef JTFRAME_DB9_6BTN_EN
    localparam logic [2:0]  PH_LAST  = 3'd7;
    localparam logic [11:0] JOY_MASK = 12'hFFF;
    localparam logic        SIX_EN   = 1'b1;
`else
    localparam logic [2:0]  PH_LAST  = 3'd1;
    // X, Y, Z and Mode do not exist on a two-phase scan
    localparam logic [11:0] JOY_MASK = 12'h4DF;
    localparam logic        SIX_EN   = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_GAP,
        ST_SEL,
        ST_SETTLE,
        ST_LOAD,
        ST_SHLO,
        ST_SHHI,
        ST_NEXT,
        ST_DONE
    } db9_state_e;

endpackage

// File: rtl/jtframe_db9_decode.sv
// -----------------------------------------------------------------------------
// jtframe_db9_decode
// Per-port Megadrive decoder. Accumulates one frame of SELECT phases into a
// shadow word and publishes it only on commit, so the outputs never show a
// partially scanned frame.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   phase_i     SELECT phase the raw lines belong to
//   raw_i       U,D,L,R,pin6,pin9 as read from the chain (active low)
//   strobe_i    raw_i is complete for phase_i
//   commit_i    copy shadow state to the outputs
//   joy_o       active-high joystick word
//   six_o       six-button pad detected
//
// Build option: JTFRAME_DB9_6BTN_EN enables phases 5/6 decoding.
// -----------------------------------------------------------------------------
module jtframe_db9_decode
    import jtframe_db9_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  phase_i,
    input  logic [5:0]  raw_i,
    input  logic        strobe_i,
    input  logic        commit_i,
    output logic [11:0] joy_o,
    output logic        six_o
);

    logic [5:0]  act;
    logic [11:0] sh_q;
    logic [11:0] joy_q;
    logic        six_sh_q;
    logic        six_q;

    assign act = ~raw_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q     <= '0;
            joy_q    <= '0;
            six_sh_q <= 1'b0;
            six_q    <= 1'b0;
        end else begin
            if (strobe_i) begin
                case (phase_i)
                    // SELECT high: directions, B, C
                    PH_DIR0, PH_DIR2, PH_DIR4: begin
                        sh_q[JOY_UP]    <= act[RAW_U];
                        sh_q[JOY_DOWN]  <= act[RAW_D];
                        sh_q[JOY_LEFT]  <= act[RAW_L];
                        sh_q[JOY_RIGHT] <= act[RAW_R];
                        sh_q[JOY_B]     <= act[RAW_P6];
                        sh_q[JOY_C]     <= act[RAW_P9];
                    end
                    // SELECT low: A and Start on the fire pins
                    PH_ABS: begin
                        sh_q[JOY_A]     <= act[RAW_P6];
                        sh_q[JOY_START] <= act[RAW_P9];
                    end
`ifdef JTFRAME_DB9_6BTN_EN
                    // A six-button pad pulls all four directions low here
                    PH_ID: six_sh_q <= (raw_i[RAW_R:RAW_U] == 4'b0000);
                    // Extra buttons; cleared for a 3-button pad so a swap
                    // between pads cannot leave stale bits behind
                    PH_EXT: begin
                        sh_q[JOY_Z]    <= six_sh_q & act[RAW_U];
                        sh_q[JOY_Y]    <= six_sh_q & act[RAW_D];
                        sh_q[JOY_X]    <= six_sh_q & act[RAW_L];
                        sh_q[JOY_MODE] <= six_sh_q & act[RAW_R];
                    end
`endif
                    default: ;
                endcase
            end
            if (commit_i) begin
                joy_q <= sh_q & JOY_MASK;
                six_q <= six_sh_q & SIX_EN;
            end
        end
    end

    assign joy_o = joy_q;
    assign six_o = six_q;

endmodule

// File: rtl/jtframe_neptuno_db9.sv
// -----------------------------------------------------------------------------
// jtframe_neptuno_db9
// Serial front end for the two DB9 ports on Neptuno/MC2 boards. Runs the
// external parallel-in shift register (joy_load/joy_clk/joy_data) and the
// shared Megadrive SELECT line through the multiplex sequence, then hands
// each port's lines to a jtframe_db9_decode instance.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   joy_clk       shift-register clock to the board
//   joy_load      shift-register parallel load, active low
//   joy_data      serial data from the board (pad lines active low)
//   joy_select    Megadrive SELECT, shared by both ports
//   joy1, joy2    active-high 12-bit joystick words
//   six1, six2    six-button pad detected
//   frame_ok      one-cycle pulse in the cycle joy1/joy2 update
//
// Parameters: CLKDIV (clk per joy_clk half period / load pulse), SETTLE
// (clk after a SELECT change), GAP (idle clk between frames).
//
// Build option: JTFRAME_DB9_6BTN_EN selects the 8-phase six-button scan;
// without it only phases 0 and 1 run.
// -----------------------------------------------------------------------------
module jtframe_neptuno_db9
    import jtframe_db9_pkg::*;
#(
    parameter int CLKDIV = 8,
    parameter int SETTLE = 16,
    parameter int GAP    = 24000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        joy_clk,
    output logic        joy_load,
    input  logic        joy_data,
    output logic        joy_select,
    output logic [11:0] joy1,
    output logic [11:0] joy2,
    output logic        six1,
    output logic        six2,
    output logic        frame_ok
);

    localparam int CMAX0 = (GAP > SETTLE) ? GAP : SETTLE;
    localparam int CMAX  = (CMAX0 > CLKDIV) ? CMAX0 : CLKDIV;
    localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] GAP_M1    = CW'(GAP - 1);
    localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);
    localparam logic [CW-1:0] DIV_M1    = CW'(CLKDIV - 1);

    db9_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [2:0]    phase_q;
    logic [5:0]    raw1_q;
    logic [5:0]    raw2_q;
    logic          joy_clk_q;
    logic          joy_load_q;
    logic          joy_select_q;
    logic          frame_ok_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_GAP;
            cnt_q        <= '0;
            bit_q        <= '0;
            phase_q      <= '0;
            raw1_q       <= '1;
            raw2_q       <= '1;
            joy_clk_q    <= 1'b0;
            joy_load_q   <= 1'b1;
            joy_select_q <= 1'b1;
            frame_ok_q   <= 1'b0;
        end else begin
            // Board pins are registered from the current state, so each pin
            // window trails its state by one clk and keeps its full length.
            // Data is sampled at the end of the SHLO state, always at least
            // one clk after the rising joy_clk edge that shifted it out.
            joy_clk_q  <= (state_q == ST_SHHI);
            joy_load_q <= (state_q != ST_LOAD);
            frame_ok_q <= (state_q == ST_DONE);

            case (state_q)
                ST_GAP: begin
                    joy_select_q <= 1'b1;
                    if (cnt_q == GAP_M1) begin
                        cnt_q   <= '0;
                        phase_q <= '0;
                        state_q <= ST_SEL;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SEL: begin
                    joy_select_q <= ~phase_q[0];
                    cnt_q        <= '0;
                    state_q      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_M1) begin
                        cnt_q   <= '0;
                        state_q <= ST_LOAD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cnt_q == DIV_M1) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= ST_SHLO;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SHLO: begin
                    if (cnt_q == DIV_M1) begin
                        cnt_q   <= '0;
                        state_q <= ST_SHHI;
                        // Bits 6/7 of each port slice are pad pins we ignore
                        if (bit_q[2:0] < 3'd6) begin
                            if (bit_q[3]) raw2_q[bit_q[2:0]] <= joy_data;
                            else          raw1_q[bit_q[2:0]] <= joy_data;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SHHI: begin
                    if (cnt_q == DIV_M1) begin
                        cnt_q <= '0;
                        if (bit_q == 4'd15) begin
                            state_q <= ST_NEXT;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            state_q <= ST_SHLO;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (phase_q == PH_LAST) begin
                        state_q <= ST_DONE;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                        state_q <= ST_SEL;
                    end
                end
                ST_DONE: begin
                    cnt_q   <= '0;
                    state_q <= ST_GAP;
                end
                default: state_q <= ST_GAP;
            endcase
        end
    end

    logic strobe;
    logic commit;

    // raw*_q is complete in NEXT; the last phase is decoded before DONE
    assign strobe = (state_q == ST_NEXT);
    assign commit = (state_q == ST_DONE);

    jtframe_db9_decode u_dec1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .phase_i  (phase_q),
        .raw_i    (raw1_q),
        .strobe_i (strobe),
        .commit_i (commit),
        .joy_o    (joy1),
        .six_o    (six1)
    );

    jtframe_db9_decode u_dec2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .phase_i  (phase_q),
        .raw_i    (raw2_q),
        .strobe_i (strobe),
        .commit_i (commit),
        .joy_o    (joy2),
        .six_o    (six2)
    );

    assign joy_clk    = joy_clk_q;
    assign joy_load   = joy_load_q;
    assign joy_select = joy_select_q;
    assign frame_ok   = frame_ok_q;

endmodule

// File: tb/tb_jtframe_neptuno_db9.sv
module tb_jtframe_neptuno_db9;

    localparam int DIV_A = 2, SET_A = 4, GAP_A = 50;
    localparam int DIV_B = 1, SET_B = 1, GAP_B = 20;

`ifdef JTFRAME_DB9_6BTN_EN
    localparam logic [11:0] EXP_J2_A   = 12'hA00;
    localparam logic        EXP_SIX2_A = 1'b1;
    localparam logic [11:0] EXP_J1_B   = 12'h071;
    localparam logic        EXP_SIX1_B = 1'b1;
    localparam int          EXP_FALLS  = 4;
`else
    localparam logic [11:0] EXP_J2_A   = 12'h000;
    localparam logic        EXP_SIX2_A = 1'b0;
    localparam logic [11:0] EXP_J1_B   = 12'h051;
    localparam logic        EXP_SIX1_B = 1'b0;
    localparam int          EXP_FALLS  = 1;
`endif

    logic clk;
    logic rst_a, rst_b;
    logic [11:0] btn1, btn2;
    int kind1, kind2;   // 0 none, 1 three-button, 2 six-button

    logic jclk_a, jload_a, jdata_a, sel_a, fok_a, six1_a, six2_a;
    logic [11:0] j1_a, j2_a;
    logic jclk_b, jload_b, jdata_b, sel_b, fok_b, six1_b, six2_b;
    logic [11:0] j1_b, j2_b;

    int nassert = 0;
    int nfail   = 0;

    jtframe_neptuno_db9 #(.CLKDIV(DIV_A), .SETTLE(SET_A), .GAP(GAP_A)) dut_a (
        .clk(clk), .rst_n(rst_a), .joy_clk(jclk_a), .joy_load(jload_a),
        .joy_data(jdata_a), .joy_select(sel_a), .joy1(j1_a), .joy2(j2_a),
        .six1(six1_a), .six2(six2_a), .frame_ok(fok_a));

    jtframe_neptuno_db9 #(.CLKDIV(DIV_B), .SETTLE(SET_B), .GAP(GAP_B)) dut_b (
        .clk(clk), .rst_n(rst_b), .joy_clk(jclk_b), .joy_load(jload_b),
        .joy_data(jdata_b), .joy_select(sel_b), .joy1(j1_b), .joy2(j2_b),
        .six1(six1_b), .six2(six2_b), .frame_ok(fok_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Megadrive pad lines (active low) for one port: [0]U [1]D [2]L [3]R
    // [4]pin6 [5]pin9 [7:6] unused high. idx = SELECT phase within the frame.
    function automatic logic [7:0] pad_lines(input logic [11:0] b, input int kind,
                                             input logic sel, input int idx);
        logic [7:0] act;
        act = 8'h00;
        if (kind == 0) return 8'hFF;
        if (kind == 2 && idx == 5) begin
            act[3:0] = 4'hF; act[4] = b[4]; act[5] = b[10];
        end else if (kind == 2 && idx == 6) begin
            act[0] = b[9]; act[1] = b[8]; act[2] = b[5]; act[3] = b[11];
            act[4] = b[7]; act[5] = b[6];
        end else if (sel) begin
            act[0] = b[3]; act[1] = b[2]; act[2] = b[1]; act[3] = b[0];
            act[4] = b[7]; act[5] = b[6];
        end else begin
            act[0] = b[3]; act[1] = b[2]; act[3:2] = 2'b11;
            act[4] = b[4]; act[5] = b[10];
        end
        return ~act;
    endfunction

    // '165 parallel word: first bit out (MSB) is port 1 Up
    function automatic logic [15:0] chain(input logic [7:0] p1, input logic [7:0] p2);
        logic [15:0] w;
        for (int j = 0; j < 8; j++) begin
            w[15-j] = p1[j];
            w[7-j]  = p2[j];
        end
        return w;
    endfunction

    // Pad phase tracking: count SELECT falls since the last frame
    int f_a = 0, f_b = 0;
    logic sd_a = 1'b1, sd_b = 1'b1;
    logic [15:0] par_a, par_b, sr_a, sr_b;

    always @(posedge clk) begin
        sd_a <= sel_a;
        sd_b <= sel_b;
        if (!rst_a || fok_a) f_a <= 0; else if (sd_a && !sel_a) f_a <= f_a + 1;
        if (!rst_b || fok_b) f_b <= 0; else if (sd_b && !sel_b) f_b <= f_b + 1;
    end

    always_comb begin
        int ia, ib;
        ia = sel_a ? 2 * f_a : 2 * f_a - 1;
        ib = sel_b ? 2 * f_b : 2 * f_b - 1;
        par_a = chain(pad_lines(btn1, kind1, sel_a, ia), pad_lines(btn2, kind2, sel_a, ia));
        par_b = chain(pad_lines(btn1, kind1, sel_b, ib), pad_lines(btn2, kind2, sel_b, ib));
    end

    always @(posedge jclk_a or negedge jload_a)
        if (!jload_a) sr_a <= par_a; else sr_a <= {sr_a[14:0], 1'b1};
    always @(posedge jclk_b or negedge jload_b)
        if (!jload_b) sr_b <= par_b; else sr_b <= {sr_b[14:0], 1'b1};

    assign jdata_a = jload_a ? sr_a[15] : par_a[15];
    assign jdata_b = jload_b ? sr_b[15] : par_b[15];

    // Outputs of instance B may only move in its frame_ok cycle
    logic mon_en = 1'b0;
    int viol = 0;
    logic [11:0] pj1_b = '0, pj2_b = '0;
    always @(negedge clk) begin
        if (mon_en && ((j1_b !== pj1_b) || (j2_b !== pj2_b)) && (fok_b !== 1'b1))
            viol <= viol + 1;
        pj1_b <= j1_b;
        pj2_b <= j2_b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nassert++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_frame_a(input string tag);
        int k;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (fok_a !== 1'b1 && k < 3000);
        chk(tag, 32'(fok_a), 32'd1);
    endtask

    task automatic wait_frame_b(input string tag);
        int k;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (fok_b !== 1'b1 && k < 3000);
        chk(tag, 32'(fok_b), 32'd1);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_clk"},  32'(jclk_a),  32'd0);
        chk({tag, "_load"}, 32'(jload_a), 32'd1);
        chk({tag, "_sel"},  32'(sel_a),   32'd1);
        chk({tag, "_j1"},   32'(j1_a),    32'd0);
        chk({tag, "_j2"},   32'(j2_a),    32'd0);
        chk({tag, "_six1"}, 32'(six1_a),  32'd0);
        chk({tag, "_six2"}, 32'(six2_a),  32'd0);
        chk({tag, "_fok"},  32'(fok_a),   32'd0);
    endtask

    initial begin
        int n, falls, rises, first, second, cyc;
        logic ps, pl, pc, found;

        rst_a = 1'b0; rst_b = 1'b0;
        btn1 = '0; btn2 = '0; kind1 = 0; kind2 = 0;
        repeat (3) @(posedge clk);
        #1 chk_reset_a("rst0");

        @(negedge clk) begin rst_a = 1'b1; rst_b = 1'b1; end
        @(negedge clk) mon_en = 1'b1;

        // Both ports unplugged
        wait_frame_a("idle_frame");
        chk("idle_j1", 32'(j1_a), 32'h000);
        chk("idle_j2", 32'(j2_a), 32'h000);
        chk("idle_six1", 32'(six1_a), 32'd0);
        chk("idle_six2", 32'(six2_a), 32'd0);
        @(posedge clk); #1 chk("fok_pulse", 32'(fok_a), 32'd0);

        // Port1 3-button Up+B+Start, port2 6-button Z+Mode
        kind1 = 1; btn1 = 12'h488;
        kind2 = 2; btn2 = 12'hA00;
        wait_frame_a("p1_frame_a");
        wait_frame_a("p1_frame_b");
        chk("p1_j1", 32'(j1_a), 32'h488);
        chk("p1_j2", 32'(j2_a), 32'(EXP_J2_A));
        chk("p1_six1", 32'(six1_a), 32'd0);
        chk("p1_six2", 32'(six2_a), 32'(EXP_SIX2_A));

        // SELECT low phases in one frame
        falls = 0; n = 0; ps = sel_a;
        do begin
            @(posedge clk); #1; n++;
            if (ps && !sel_a) falls++;
            ps = sel_a;
        end while (fok_a !== 1'b1 && n < 3000);
        chk("sel_falls", 32'(falls), 32'(EXP_FALLS));

        // Port1 6-button Right+A+X+C, port2 3-button Left+Down+A+C
        kind1 = 2; btn1 = 12'h071;
        kind2 = 1; btn2 = 12'h056;
        wait_frame_a("p2_frame_a");
        wait_frame_a("p2_frame_b");
        chk("p2_j1", 32'(j1_a), 32'(EXP_J1_B));
        chk("p2_j2", 32'(j2_a), 32'h056);
        chk("p2_six1", 32'(six1_a), 32'(EXP_SIX1_B));
        chk("p2_six2", 32'(six2_a), 32'd0);

        // Reset for 3 cycles while joy_clk is high mid-scan
        n = 0;
        do begin @(posedge clk); #1; n++; end while (jclk_a !== 1'b1 && n < 3000);
        chk("find_shhi", 32'(jclk_a), 32'd1);
        @(negedge clk) rst_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_a("rst_mid");
        @(negedge clk) rst_a = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (jload_a !== 1'b0 && n < 1000);
        chk("load_delay", 32'(n), 32'(GAP_A + 1 + SET_A + 1));

        // Instance B, CLKDIV=1 / SETTLE=1
        wait_frame_b("b_frame_a");
        wait_frame_b("b_frame_b");
        chk("b_j1", 32'(j1_b), 32'(EXP_J1_B));
        chk("b_j2", 32'(j2_b), 32'h056);
        chk("b_six1", 32'(six1_b), 32'(EXP_SIX1_B));

        n = 0; pl = jload_b; found = 1'b0;
        do begin
            @(posedge clk); #1; n++;
            found = pl && !jload_b;
            pl = jload_b;
        end while (!found && n < 2000);
        chk("b_load_seen", 32'(found), 32'd1);

        rises = 0; first = -1; second = -1; cyc = 0; pc = jclk_b; found = 1'b0;
        do begin
            @(posedge clk); #1; cyc++;
            if (!pc && jclk_b) begin
                rises++;
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
            pc = jclk_b;
            found = pl && !jload_b;
            pl = jload_b;
        end while (!found && cyc < 2000);
        chk("b_next_load", 32'(found), 32'd1);
        chk("b_rises", 32'(rises), 32'd16);
        chk("b_period", 32'(second - first), 32'd2);

        @(negedge clk);
        chk("b_no_partial", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
